// File: rtl/sync_reset_gen_pkg.sv
// Shared state encoding and parameter limits for sync_reset_gen.
package sync_reset_gen_pkg;

   typedef logic [1:0] state_t;

   localparam state_t StReset = 2'd0;
   localparam state_t StSync  = 2'd1;
   localparam state_t StHold  = 2'd2;
   localparam state_t StRun   = 2'd3;

   localparam int unsigned RSTDELAY_MIN = 2;
   localparam int unsigned RSTDELAY_MAX = 8;

   function automatic logic is_run(state_t s);
      return s == StRun;
   endfunction

endpackage

// File: rtl/sync_reset_gen_if.sv
// Status/request bundle between sync_reset_gen and its controlling logic.
// ASSERT_IN exists only when SYNC_RESET_GEN_SWRST_EN is defined.
interface sync_reset_gen_if;

   logic RST_OUT_N;
   logic IN_RESET;
   logic RST_DONE;

`ifdef SYNC_RESET_GEN_SWRST_EN
   logic ASSERT_IN;

   modport master (output RST_OUT_N, output IN_RESET, output RST_DONE, input ASSERT_IN);
   modport slave  (input RST_OUT_N, input IN_RESET, input RST_DONE, output ASSERT_IN);
`else
   modport master (output RST_OUT_N, output IN_RESET, output RST_DONE);
   modport slave  (input RST_OUT_N, input IN_RESET, input RST_DONE);
`endif

endinterface

// File: rtl/reset_sync_chain.sv
// RSTDELAY-deep async-clear flop chain; sync_out is the synchronised release.
module reset_sync_chain #(
   parameter int unsigned RSTDELAY = 2
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic din,
   output logic sync_out,
   output logic rise_next
);

   logic [RSTDELAY-1:0] stage_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stage_q <= '0;
      end else begin
         stage_q <= {stage_q[RSTDELAY-2:0], din};
      end
   end

   assign sync_out  = stage_q[RSTDELAY-1];
   // High in the cycle before sync_out rises, so the FSM can move on that same edge.
   assign rise_next = stage_q[RSTDELAY-2] & ~stage_q[RSTDELAY-1];

endmodule

// File: rtl/sync_reset_gen.sv
// Reset generator: async assert, synchronised release, programmable hold.
// Software reset request is built in when SYNC_RESET_GEN_SWRST_EN is defined.
module sync_reset_gen
   import sync_reset_gen_pkg::*;
#(
   parameter int unsigned RSTDELAY = 2,
   parameter int unsigned RSTHOLD  = 16,
   parameter int unsigned CNTW     = 8
) (
   input logic             CLK,
   input logic             RST_N,
   sync_reset_gen_if.master bus
);

   if (RSTDELAY < RSTDELAY_MIN || RSTDELAY > RSTDELAY_MAX) begin : g_bad_delay
      $error("sync_reset_gen: RSTDELAY out of range 2..8");
   end
   if (longint'(RSTHOLD) >= (longint'(1) << CNTW)) begin : g_bad_cntw
      $error("sync_reset_gen: CNTW too narrow for RSTHOLD");
   end

   localparam logic [CNTW-1:0] HoldLast = CNTW'(RSTHOLD - 1);

   logic released;
   logic release_next;
   logic sw_req;

   reset_sync_chain #(
      .RSTDELAY (RSTDELAY)
   ) u_chain (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .din       (1'b1),
      .sync_out  (released),
      .rise_next (release_next)
   );

`ifdef SYNC_RESET_GEN_SWRST_EN
   assign sw_req = bus.ASSERT_IN;
`else
   assign sw_req = 1'b0;
`endif

   state_t          state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            hold_done;
   logic            rst_out_q, in_reset_q, done_q;

   // HOLD can be entered with RSTHOLD == 0 only via software reset; leave after one edge.
   assign hold_done = (RSTHOLD == 0) || (cnt_q == HoldLast);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StReset: state_d = StSync;
         StSync: begin
            if (release_next || released) begin
               cnt_d   = '0;
               state_d = (RSTHOLD == 0) ? StRun : StHold;
            end
         end
         StHold: begin
            if (sw_req) begin
               cnt_d = '0;
            end else if (hold_done) begin
               state_d = StRun;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         StRun: begin
            if (sw_req) begin
               state_d = StHold;
               cnt_d   = '0;
            end
         end
         default: state_d = StReset;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= StReset;
         cnt_q      <= '0;
         rst_out_q  <= 1'b0;
         in_reset_q <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rst_out_q  <= is_run(state_d);
         in_reset_q <= !is_run(state_d);
         done_q     <= is_run(state_d) && !is_run(state_q);
      end
   end

   assign bus.RST_OUT_N = rst_out_q;
   assign bus.IN_RESET  = in_reset_q;
   assign bus.RST_DONE  = done_q;

endmodule

// File: tb/tb_sync_reset_gen.sv
// Bench for sync_reset_gen: two instances (defaults, and RSTDELAY=3/RSTHOLD=0)
// checked every cycle against an edge-count model, plus directed literal checks.
module tb_sync_reset_gen;

   localparam int DA = 2;
   localparam int HA = 16;
   localparam int DB = 3;
   localparam int HB = 0;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic sw = 1'b0;

   int n_cmp = 0;
   int n_fail = 0;

   sync_reset_gen_if bus_a ();
   sync_reset_gen_if bus_b ();

`ifdef SYNC_RESET_GEN_SWRST_EN
   assign bus_a.ASSERT_IN = sw;
   assign bus_b.ASSERT_IN = sw;
`endif

   sync_reset_gen #(.RSTDELAY(DA), .RSTHOLD(HA), .CNTW(8)) dut_a (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus_a)
   );

   sync_reset_gen #(.RSTDELAY(DB), .RSTHOLD(HB), .CNTW(4)) dut_b (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
      end
   endtask

   // Model: count edges since release; release edge moves on an accepted sw request.
   int e_q = 0;
   int rel_a = DA + HA;
   int rel_b = DB + HB;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q   <= 0;
         rel_a <= DA + HA;
         rel_b <= DB + HB;
      end else begin
         e_q <= e_q + 1;
         if (sw && (e_q + 1 > DA)) rel_a <= e_q + 1 + ((HA == 0) ? 1 : HA);
         if (sw && (e_q + 1 > DB)) rel_b <= e_q + 1 + ((HB == 0) ? 1 : HB);
      end
   end

   always @(negedge clk) begin
      check("a_rst_out_n", int'(bus_a.RST_OUT_N), int'(e_q >= rel_a));
      check("a_in_reset",  int'(bus_a.IN_RESET),  int'(e_q <  rel_a));
      check("a_rst_done",  int'(bus_a.RST_DONE),  int'(e_q == rel_a));
      check("b_rst_out_n", int'(bus_b.RST_OUT_N), int'(e_q >= rel_b));
      check("b_in_reset",  int'(bus_b.IN_RESET),  int'(e_q <  rel_b));
      check("b_rst_done",  int'(bus_b.RST_DONE),  int'(e_q == rel_b));
   end

   // Release from reset at a negedge and pin the default release timing.
   task automatic release_and_check(input string tag);
      rst_n = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         @(negedge clk);
         if (e == 2)  check({tag, "_b_low_e2"}, int'(bus_b.RST_OUT_N), 0);
         if (e == 3)  check({tag, "_b_high_e3"}, int'(bus_b.RST_OUT_N), 1);
         if (e == 3)  check({tag, "_b_done_e3"}, int'(bus_b.RST_DONE), 1);
         if (e == 4)  check({tag, "_b_done_e4"}, int'(bus_b.RST_DONE), 0);
         if (e == 17) check({tag, "_a_low_e17"}, int'(bus_a.RST_OUT_N), 0);
         if (e == 17) check({tag, "_a_inrst_e17"}, int'(bus_a.IN_RESET), 1);
         if (e == 18) check({tag, "_a_high_e18"}, int'(bus_a.RST_OUT_N), 1);
         if (e == 18) check({tag, "_a_done_e18"}, int'(bus_a.RST_DONE), 1);
         if (e == 18) check({tag, "_a_inrst_e18"}, int'(bus_a.IN_RESET), 0);
         if (e == 19) check({tag, "_a_done_e19"}, int'(bus_a.RST_DONE), 0);
      end
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (5) @(negedge clk);
      check("por_a_out", int'(bus_a.RST_OUT_N), 0);
      check("por_a_inrst", int'(bus_a.IN_RESET), 1);
      check("por_a_done", int'(bus_a.RST_DONE), 0);
      check("por_b_out", int'(bus_b.RST_OUT_N), 0);

      release_and_check("por");
      repeat (10) @(negedge clk);
      check("run_idle_a", int'(bus_a.RST_OUT_N), 1);

`ifdef SYNC_RESET_GEN_SWRST_EN
      // One-cycle software request in RUN.
      sw = 1'b1;
      @(negedge clk);
      sw = 1'b0;
      check("sw_a_low", int'(bus_a.RST_OUT_N), 0);
      check("sw_b_low", int'(bus_b.RST_OUT_N), 0);
      repeat (15) @(negedge clk);
      check("sw_a_still_low", int'(bus_a.RST_OUT_N), 0);
      @(negedge clk);
      check("sw_a_high", int'(bus_a.RST_OUT_N), 1);
      check("sw_a_done", int'(bus_a.RST_DONE), 1);
      repeat (5) @(negedge clk);

      // Re-assert while the hold counter reads 12.
      sw = 1'b1;
      @(negedge clk);
      sw = 1'b0;
      repeat (12) @(negedge clk);
      sw = 1'b1;
      @(negedge clk);
      sw = 1'b0;
      repeat (15) @(negedge clk);
      check("reassert_a_low", int'(bus_a.RST_OUT_N), 0);
      @(negedge clk);
      check("reassert_a_high", int'(bus_a.RST_OUT_N), 1);
      check("reassert_a_done", int'(bus_a.RST_DONE), 1);

      // Held request extends reset indefinitely.
      sw = 1'b1;
      repeat (40) @(negedge clk);
      check("held_a_low", int'(bus_a.RST_OUT_N), 0);
      check("held_b_low", int'(bus_b.RST_OUT_N), 0);
      sw = 1'b0;
      repeat (16) @(negedge clk);
      check("held_a_high", int'(bus_a.RST_OUT_N), 1);

      // RST_N and request together: RST_N wins; request ignored in RESET/SYNC.
      sw = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      check("both_a_out", int'(bus_a.RST_OUT_N), 0);
      check("both_a_inrst", int'(bus_a.IN_RESET), 1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      sw = 1'b0;
      repeat (15) @(negedge clk);
      check("both_a_low_e17", int'(bus_a.RST_OUT_N), 0);
      @(negedge clk);
      check("both_a_high_e18", int'(bus_a.RST_OUT_N), 1);
      repeat (3) @(negedge clk);
`endif

      // Abort mid-HOLD with no clock edge in between.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("hold_a_cnt_state", int'(dut_a.state_q), 2);
      #2 rst_n = 1'b0;
      #1;
      check("abort_a_out", int'(bus_a.RST_OUT_N), 0);
      check("abort_a_inrst", int'(bus_a.IN_RESET), 1);
      check("abort_a_done", int'(bus_a.RST_DONE), 0);
      check("abort_a_state", int'(dut_a.state_q), 0);
      @(negedge clk);
      release_and_check("rerel");

      // Async drop from RUN must pull outputs low before any clock edge.
      #2 rst_n = 1'b0;
      #1;
      check("run_drop_a_out", int'(bus_a.RST_OUT_N), 0);
      check("run_drop_a_inrst", int'(bus_a.IN_RESET), 1);
      check("run_drop_b_out", int'(bus_b.RST_OUT_N), 0);
      @(negedge clk);
      release_and_check("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
